// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit: NIN operands reduced per bit by a per-transaction op,
// results delivered through a two-entry (main + skid) valid/ready output buffer.
module logic_pipe #(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [NIN*WIDTH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [2:0]             out_op,
    output logic [CNT_W-1:0]       count,
    output logic                   op_err
);

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] result;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic [2:0]       main_op;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [2:0]       skid_op;

    logic             accept;
    logic             handshake;

    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int i = 0; i < NIN; i++) begin
            and_r = and_r & in_data[i*WIDTH +: WIDTH];
            or_r  = or_r  | in_data[i*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = '0;
        case (in_op)
            OP_NAND: result = ~and_r;
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_NOR:  result = ~or_r;
            OP_XOR:  result = xor_r;
            OP_XNOR: result = ~xor_r;
            OP_NOT:  result = ~in_data[WIDTH-1:0];
            default: result = '0;
        endcase
    end

    // in_ready comes straight from the skid flop, so it never depends on out_ready.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign handshake = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_op    = main_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_op    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_op    <= '0;
            count      <= '0;
            op_err     <= 1'b0;
        end else begin
            if (handshake) begin
                count <= count + CNT_W'(1);
            end
            if (accept && (in_op == OP_ILL)) begin
                op_err <= 1'b1;
            end

            // Main: refill from skid first to keep FIFO order, else from the input.
            if (handshake) begin
                if (skid_valid) begin
                    main_data <= skid_data;
                    main_op   <= skid_op;
                end else if (accept) begin
                    main_data <= result;
                    main_op   <= in_op;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (!main_valid && accept) begin
                main_valid <= 1'b1;
                main_data  <= result;
                main_op    <= in_op;
            end

            if (handshake && skid_valid) begin
                skid_valid <= accept;
                if (accept) begin
                    skid_data <= result;
                    skid_op   <= in_op;
                end
            end else if (accept && main_valid && !handshake) begin
                skid_valid <= 1'b1;
                skid_data  <= result;
                skid_op    <= in_op;
            end
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe: truth table, all ops, backpressure, illegal op,
// counter wrap and reset during a full buffer.
module tb_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] in_op;
    logic [7:0] in_data;
    logic [1:0] d1;

    logic        rdy4, val4, err4;
    logic [3:0]  dat4;
    logic [2:0]  op4;
    logic [15:0] cnt4;

    logic        rdy1, val1, err1;
    logic [0:0]  dat1;
    logic [2:0]  op1;
    logic [15:0] cnt1;

    logic        rdyc, valc, errc;
    logic [3:0]  datc;
    logic [2:0]  opc;
    logic [1:0]  cntc;

    logic_pipe #(.WIDTH(4), .NIN(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op),
        .in_data(in_data), .out_valid(val4), .out_ready(out_ready), .out_data(dat4),
        .out_op(op4), .count(cnt4), .op_err(err4));

    logic_pipe #(.WIDTH(1), .NIN(2), .CNT_W(16)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
        .in_data(d1), .out_valid(val1), .out_ready(out_ready), .out_data(dat1),
        .out_op(op1), .count(cnt1), .op_err(err1));

    logic_pipe #(.WIDTH(4), .NIN(2), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyc), .in_op(in_op),
        .in_data(in_data), .out_valid(valc), .out_ready(out_ready), .out_data(datc),
        .out_op(opc), .count(cntc), .op_err(errc));

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t ops_tab [7];
    logic tt_exp [4];
    logic [1:0] wrap_exp [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        ops_tab[0] = '{3'd0, 4'b1100, 4'b1010, 4'b0111};
        ops_tab[1] = '{3'd1, 4'b1100, 4'b1010, 4'b1000};
        ops_tab[2] = '{3'd2, 4'b1100, 4'b1010, 4'b1110};
        ops_tab[3] = '{3'd3, 4'b1100, 4'b1010, 4'b0001};
        ops_tab[4] = '{3'd4, 4'b1100, 4'b1010, 4'b0110};
        ops_tab[5] = '{3'd5, 4'b1100, 4'b1010, 4'b1001};
        ops_tab[6] = '{3'd6, 4'b1100, 4'b1010, 4'b0011};
        tt_exp     = '{1'b1, 1'b1, 1'b1, 1'b0};
        wrap_exp   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_data = '0; d1 = '0;

        // reset state
        do_reset();
        chk("rst_out_valid", 32'(val4), 32'd0);
        chk("rst_out_data", 32'(dat4), 32'd0);
        chk("rst_out_op", 32'(op4), 32'd0);
        chk("rst_count", 32'(cnt4), 32'd0);
        chk("rst_op_err", 32'(err4), 32'd0);
        chk("rst_in_ready", 32'(rdy4), 32'd1);

        // NAND truth table, WIDTH=1
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_op = 3'd0;
            d1 = 2'(i);
            tick();
            chk("tt_valid", 32'(val1), 32'd1);
            chk("tt_data", 32'(dat1), 32'(tt_exp[i]));
        end
        in_valid = 1'b0;
        tick();

        // all ops, WIDTH=4
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_op = ops_tab[i].op;
            in_data = {ops_tab[i].b, ops_tab[i].a};
            tick();
            chk("ops_valid", 32'(val4), 32'd1);
            chk("ops_data", 32'(dat4), 32'(ops_tab[i].exp));
            chk("ops_op", 32'(op4), 32'(ops_tab[i].op));
            chk("ops_in_ready", 32'(rdy4), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("ops_count", 32'(cnt4), 32'd7);
        chk("ops_drained", 32'(val4), 32'd0);
        chk("ops_hold_data", 32'(dat4), 32'(4'b0011));

        // backpressure: data 1,2,3 passed through OR with zero
        do_reset();
        out_ready = 1'b0;
        in_op = 3'd2;
        in_valid = 1'b1;
        in_data = 8'h01;
        tick();
        chk("bp_rdy1", 32'(rdy4), 32'd1);
        chk("bp_data1", 32'(dat4), 32'd1);
        in_data = 8'h02;
        tick();
        chk("bp_rdy2", 32'(rdy4), 32'd0);
        chk("bp_hold2", 32'(dat4), 32'd1);
        in_data = 8'h03;
        tick();
        chk("bp_rdy3", 32'(rdy4), 32'd0);
        chk("bp_hold3", 32'(dat4), 32'd1);
        chk("bp_hold3_op", 32'(op4), 32'd2);
        out_ready = 1'b1;
        tick();
        chk("bp_out2", 32'(dat4), 32'd2);
        chk("bp_rdy_back", 32'(rdy4), 32'd1);
        tick();
        chk("bp_out3", 32'(dat4), 32'd3);
        chk("bp_valid3", 32'(val4), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(val4), 32'd0);
        chk("bp_count", 32'(cnt4), 32'd3);

        // illegal op, sticky flag
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_op = 3'd7;
        in_data = 8'hff;
        tick();
        chk("ill_data", 32'(dat4), 32'd0);
        chk("ill_op", 32'(op4), 32'd7);
        chk("ill_err", 32'(err4), 32'd1);
        in_op = 3'd1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hf0 | i);
            tick();
            chk("ill_sticky", 32'(err4), 32'd1);
            chk("ill_legal_op", 32'(op4), 32'd1);
        end
        do_reset();
        chk("ill_cleared", 32'(err4), 32'd0);

        // counter wrap on CNT_W=2
        out_ready = 1'b1;
        in_op = 3'd2;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 5);
            in_data = 8'(i);
            tick();
            if (i >= 1) begin
                chk("wrap_count", 32'(cntc), 32'(wrap_exp[i-1]));
                chk("wrap_wide_count", 32'(cnt4), 32'(i));
            end
        end
        in_valid = 1'b0;

        // reset with main and skid full
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd7;
        in_data = 8'h05;
        tick();
        in_op = 3'd2;
        in_data = 8'h06;
        tick();
        chk("mid_full", 32'(rdy4), 32'd0);
        chk("mid_err_pre", 32'(err4), 32'd1);
        rst = 1'b1;
        in_data = 8'h09;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_valid", 32'(val4), 32'd0);
        chk("mid_count", 32'(cnt4), 32'd0);
        chk("mid_err", 32'(err4), 32'd0);
        chk("mid_in_ready", 32'(rdy4), 32'd1);
        chk("mid_data", 32'(dat4), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", 32'(val4), 32'd0);
        end
        chk("mid_count_after", 32'(cnt4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
